// File: rtl/alu_rr_scheduler_pkg.sv
// Shared types and sizes for the round-robin ALU select scheduler.
package alu_rr_scheduler_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned SELW = 3;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

endpackage

// File: rtl/alu_rr_scheduler_rr_pick8.sv
// Combinational round-robin picker: first set request bit at or after ptr, modulo 8.
module rr_pick8
    import alu_rr_scheduler_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [NREQ-1:0] rot;
    logic [SELW-1:0] off;

    // Rotate right by ptr so the search always starts at bit 0.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            rot[k] = req[SELW'(k) + ptr];
        end
    end

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = SELW'(k);
            end
        end
    end

    assign idx = off + ptr;

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 8-input ALU selector; holds each grant HOLD
// cycles, then captures alu_y tagged with the requester index.
module alu_rr_scheduler
    import alu_rr_scheduler_pkg::*;
#(
    parameter int unsigned HOLD  = 2,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [SELW-1:0]  alu_s,
    input  logic [WIDTH-1:0] alu_y,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_src
);

    localparam logic [3:0] CntInit = 4'(HOLD - 1);

    if (HOLD < 1 || HOLD > 15) begin : g_hold_check
        $error("alu_rr_scheduler: HOLD must be in 1..15");
    end

    state_e          state_q;
    logic [SELW-1:0] ptr_q;
    logic [3:0]      cnt_q;
    logic            found;
    logic [SELW-1:0] pick_idx;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cnt_q     <= '0;
            alu_s     <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en && found) begin
                        alu_s   <= pick_idx;
                        gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy    <= 1'b1;
                        cnt_q   <= CntInit;
                        state_q <= StGrant;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                StGrant: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        out_data  <= alu_y;
                        out_src   <= alu_s;
                        out_valid <= 1'b1;
                        gnt       <= '0;
                        busy      <= 1'b0;
                        ptr_q     <= alu_s + 3'd1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
